// File: rtl/sdram_sched_pkg.sv
// Shared types and defaults for the SDRAM port scheduler: ownership states,
// default bus widths and the all-lanes byte-enable pattern used by streaming.
package sdram_sched_pkg;

  localparam int DEF_ADDR_W   = 25;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_BUF_LOG2 = 11;
  localparam int DEF_MAX_OUT  = 8;

  localparam logic [1:0] AV_BE_ALL = 2'b11;

  typedef enum logic [1:0] {
    S_STREAM,
    S_DRAIN_S,
    S_WRITE,
    S_DRAIN_W
  } state_t;

  // Read data belongs to the prefetcher in both stream-side states.
  function automatic logic stream_owns_data(input state_t s);
    return (s == S_STREAM) || (s == S_DRAIN_S);
  endfunction

endpackage

// File: rtl/sched_credit_ctr.sv
// Up/down counter: +1 on inc, -1 on dec, unchanged when both fire together.
// A decrement at zero is dropped and an increment at MAX is dropped.
module sched_credit_ctr #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         dec_ok;

  always_comb begin
    cnt_d  = cnt_q;
    dec_ok = dec_i && (cnt_q != '0);
    if (inc_i && !dec_ok) begin
      if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
    end else if (dec_ok && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sdram_port_scheduler.sv
// Shares the single SDRAM Avalon port between the JTAG write master and the
// credit-throttled stream prefetcher; ownership moves only once reads drain.
module sdram_port_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BUF_LOG2 = DEF_BUF_LOG2,
  parameter int MAX_OUT  = DEF_MAX_OUT
) (
  input  logic                M100CLK,
  input  logic                lock,
  input  logic                wr_sel,
  input  logic [ADDR_W-1:0]   stream_len,
  input  logic                wm_cs,
  input  logic                wm_read,
  input  logic                wm_write,
  input  logic [ADDR_W-1:0]   wm_addr,
  input  logic [1:0]          wm_be,
  input  logic [DATA_W-1:0]   wm_wdata,
  output logic                wm_waitreq,
  output logic [DATA_W-1:0]   wm_rdata,
  output logic                wm_rvalid,
  input  logic                rs_consume,
  output logic [DATA_W-1:0]   rs_rdata,
  output logic                rs_rvalid,
  output logic [BUF_LOG2:0]   rs_level,
  output logic                av_cs,
  output logic                av_read,
  output logic                av_write,
  output logic [ADDR_W-1:0]   av_addr,
  output logic [1:0]          av_be,
  output logic [DATA_W-1:0]   av_wdata,
  input  logic [DATA_W-1:0]   av_rdata,
  input  logic                av_rvalid,
  input  logic                av_waitreq,
  output logic                owner_wr
);

  localparam int OUT_W  = $clog2(MAX_OUT + 1);
  localparam int OUTX_W = OUT_W + 1;
  localparam int LVL_W  = BUF_LOG2 + 1;
  localparam int SUM_W  = LVL_W + 1;

  localparam logic [SUM_W-1:0]  CREDITS   = SUM_W'(2 ** BUF_LOG2);
  localparam logic [OUTX_W-1:0] MAX_OUT_V = OUTX_W'(MAX_OUT);

  state_t state_q, state_d;

  logic              av_read_q, av_read_d;
  logic [ADDR_W-1:0] av_addr_q, av_addr_d;
  logic [ADDR_W-1:0] str_addr_q, str_addr_d;

  logic [OUT_W-1:0]  str_out;
  logic [OUT_W-1:0]  wm_out;
  logic [LVL_W-1:0]  level;

  logic              stream_side;
  logic              str_accept;
  logic              wm_accept;
  logic              wm_cmd_pending;
  logic              len_active;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] inc_addr;
  logic              wrap_now;
  logic [SUM_W-1:0]  committed;
  logic [OUTX_W-1:0] in_flight;
  logic              issue;

  assign stream_side    = stream_owns_data(state_q);
  assign str_accept     = av_read_q && !av_waitreq;
  assign wm_accept      = (state_q == S_WRITE) && wm_cs && wm_read && !av_waitreq;
  assign wm_cmd_pending = wm_cs && (wm_read || wm_write);

  // Responses are only forwarded to a side that has a read outstanding.
  assign rs_rvalid = av_rvalid && stream_side && (str_out != '0);
  assign wm_rvalid = av_rvalid && !stream_side && (wm_out != '0);
  assign rs_rdata  = av_rdata;
  assign wm_rdata  = av_rdata;
  assign rs_level  = level;
  assign owner_wr  = (state_q == S_WRITE) || (state_q == S_DRAIN_W);

  // An address left beyond a shortened stream restarts from zero at once.
  assign len_active = (stream_len != '0);
  assign issue_addr = (len_active && (str_addr_q >= stream_len)) ? '0 : str_addr_q;
  assign inc_addr   = issue_addr + 1'b1;
  assign wrap_now   = len_active && (inc_addr == stream_len);

  // The presented-but-unaccepted read already holds a credit and a slot.
  assign committed = SUM_W'(level) + SUM_W'(str_out) + SUM_W'(av_read_q);
  assign in_flight = OUTX_W'(str_out) + OUTX_W'(av_read_q);
  assign issue     = (state_q == S_STREAM) && (!av_read_q || str_accept) &&
                     (committed < CREDITS) && (in_flight < MAX_OUT_V);

  always_comb begin
    av_read_d  = av_read_q;
    av_addr_d  = av_addr_q;
    str_addr_d = str_addr_q;
    if (issue) begin
      av_read_d  = 1'b1;
      av_addr_d  = issue_addr;
      str_addr_d = wrap_now ? '0 : inc_addr;
    end else if (str_accept) begin
      av_read_d  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_STREAM:  if (wr_sel) state_d = S_DRAIN_S;
      // A read still waiting for acceptance must land before handing over.
      S_DRAIN_S: if ((str_out == '0) && !av_read_q) state_d = S_WRITE;
      S_WRITE:   if (!wr_sel && !wm_cmd_pending && (wm_out == '0)) state_d = S_DRAIN_W;
      S_DRAIN_W: if (wm_out == '0) state_d = S_STREAM;
      default:   state_d = S_STREAM;
    endcase
  end

  // NOTE: every combinational output gets its default first, so no branch
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    av_cs      = av_read_q;
    av_read    = av_read_q;
    av_write   = 1'b0;
    av_addr    = av_addr_q;
    av_be      = AV_BE_ALL;
    av_wdata   = '0;
    wm_waitreq = 1'b1;
    if (state_q == S_WRITE) begin
      av_cs      = wm_cs;
      av_read    = wm_read;
      av_write   = wm_write;
      av_addr    = wm_addr;
      av_be      = wm_be;
      av_wdata   = wm_wdata;
      wm_waitreq = av_waitreq;
    end
  end

  always_ff @(posedge M100CLK or negedge lock) begin
    if (!lock) begin
      state_q    <= S_STREAM;
      av_read_q  <= 1'b0;
      av_addr_q  <= '0;
      str_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      av_read_q  <= av_read_d;
      av_addr_q  <= av_addr_d;
      str_addr_q <= str_addr_d;
    end
  end

  sched_credit_ctr #(.W(OUT_W), .MAX(MAX_OUT)) u_str_out (
    .clk   (M100CLK),
    .rst_n (lock),
    .inc_i (str_accept),
    .dec_i (rs_rvalid),
    .cnt_o (str_out)
  );

  sched_credit_ctr #(.W(OUT_W), .MAX(MAX_OUT)) u_wm_out (
    .clk   (M100CLK),
    .rst_n (lock),
    .inc_i (wm_accept),
    .dec_i (wm_rvalid),
    .cnt_o (wm_out)
  );

  sched_credit_ctr #(.W(LVL_W), .MAX(2 ** BUF_LOG2)) u_level (
    .clk   (M100CLK),
    .rst_n (lock),
    .inc_i (rs_rvalid),
    .dec_i (rs_consume),
    .cnt_o (level)
  );

endmodule
